// File: rtl/mac_array_pkg.sv
// mac_array_pkg: shared FSM state type, derived-width helpers and the output saturation function.
package mac_array_pkg;

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, OUT} state_e;

    function automatic int acc_w(input int dw, input int k_max);
        return 2 * dw + $clog2(k_max);
    endfunction

    function automatic int kw(input int k_max);
        return $clog2(k_max + 1);
    endfunction

    // Clamps a into the signed range of a w-bit value; the caller keeps the low w bits.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] a, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (a > hi) ? hi : (a < lo) ? lo : a;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// mac_lane: one MAC lane; registers the signed product, then accumulates it when its valid bit is set.
module mac_lane #(
    parameter int DW    = 8,
    parameter int ACC_W = 20
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic                    clr,
    input  logic                    vld,
    input  logic signed [DW-1:0]    w,
    input  logic signed [DW-1:0]    x,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*DW-1:0] p;
    logic                   pv;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            p   <= '0;
            pv  <= 1'b0;
            acc <= '0;
        end else begin
            p   <= (2*DW)'(w) * (2*DW)'(x);
            pv  <= vld;
            acc <= clr ? '0 : pv ? acc + ACC_W'(p) : acc;
        end
    end

endmodule

// File: rtl/mac_array_stream.sv
// mac_array_stream: LANES-wide streaming dot-product engine with a reusable weight buffer.
// Define MAC_ARRAY_SAT_EN to saturate result lanes instead of wrapping them.
module mac_array_stream
    import mac_array_pkg::*;
#(
    parameter int LANES = 5,
    parameter int DW    = 8,
    parameter int K_MAX = 16,
    parameter int OUT_W = 8,
    localparam int KW   = kw(K_MAX)
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   start_i,
    input  logic [KW-1:0]          k_len_i,
    input  logic                   keep_w_i,
    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    input  logic [LANES*DW-1:0]    w_data_i,
    input  logic                   x_valid_i,
    output logic                   x_ready_o,
    input  logic [LANES*DW-1:0]    x_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [LANES*OUT_W-1:0] out_data_o,
    output logic [LANES-1:0]       ov_o,
    output logic                   busy_o
);

    localparam int ACC_W = acc_w(DW, K_MAX);
    localparam int AW    = $clog2(K_MAX);

    state_e                  state, nxt;
    logic [KW-1:0]           cnt, kl;
    logic                    w_loaded;
    logic [LANES*DW-1:0]     wbuf [K_MAX];
    logic                    w_fire, x_fire, last, clr;
    logic signed [ACC_W-1:0] acc [LANES];
    logic [LANES*OUT_W-1:0]  res;
    logic [LANES-1:0]        ov_n;

    assign w_ready_o   = state == LOAD_W;
    assign x_ready_o   = state == STREAM;
    assign out_valid_o = state == OUT;
    assign busy_o      = state != IDLE;
    assign w_fire      = w_valid_i && w_ready_o;
    assign x_fire      = x_valid_i && x_ready_o;
    assign last        = cnt == kl - 1'b1;
    assign clr         = state == IDLE && nxt != IDLE;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start_i && |k_len_i) nxt = (keep_w_i && w_loaded) ? STREAM : LOAD_W;
            LOAD_W:  if (w_fire && last) nxt = STREAM;
            STREAM:  if (x_fire && last) nxt = DRAIN;
            DRAIN:   if (cnt == KW'(2)) nxt = OUT;
            OUT:     if (out_ready_i) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state <= IDLE;
        else       state <= nxt;
    end

    // cnt restarts on every state change, so it doubles as beat index and drain timer.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt        <= '0;
            kl         <= '0;
            w_loaded   <= 1'b0;
            out_data_o <= '0;
            ov_o       <= '0;
        end else begin
            if (clr) kl <= (k_len_i > KW'(K_MAX)) ? KW'(K_MAX) : k_len_i;
            if (state != nxt) cnt <= '0;
            else if (w_fire || x_fire || state == DRAIN) cnt <= cnt + 1'b1;
            if (w_fire && last) w_loaded <= 1'b1;
            if (state == DRAIN && nxt == OUT) begin
                out_data_o <= res;
                ov_o       <= ov_n;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_fire) wbuf[cnt[AW-1:0]] <= w_data_i;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [63:0] sat;
        mac_lane #(.DW(DW), .ACC_W(ACC_W)) u_lane (
            .CLK (CLK),
            .RSTN(RSTN),
            .clr (clr),
            .vld (x_fire),
            .w   (wbuf[cnt[AW-1:0]][i*DW +: DW]),
            .x   (x_data_i[i*DW +: DW]),
            .acc (acc[i])
        );
        assign sat     = saturate(64'(acc[i]), OUT_W);
        assign ov_n[i] = sat != 64'(acc[i]);
`ifdef MAC_ARRAY_SAT_EN
        assign res[i*OUT_W +: OUT_W] = sat[OUT_W-1:0];
`else
        assign res[i*OUT_W +: OUT_W] = acc[i][OUT_W-1:0];
`endif
    end

endmodule
